abs_diff_pipe: RTL and testbench
================================

Name: abs_diff_pipe

Overview:
Pipelined, parametrised absolute-difference engine for the edge-preserving noise filter datapath. It supersedes the single 8-bit combinational abs-subtractor.
- Processes LANES unsigned pixel pairs per beat.
- Produces per-lane |a-b|, a sign bit and an edge flag against a programmable threshold.
- Produces a cross-lane sum of absolute differences (SAD).
- Sits between the window/line-buffer stage and the weight/blend stage, with valid/ready flow control on both sides.

Parameters:
- WIDTH, 8: pixel component width in bits (unsigned), >= 2.
- LANES, 4: number of independent pixel pairs per beat, >= 1.
- SAD_W, derived (localparam), WIDTH + clog2(LANES), or WIDTH when LANES = 1: SAD output width.

Ports:
- clk  in  1  rising-edge clock, single clock domain.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  input beat valid.
- in_ready  out  1  block can accept an input beat this cycle.
- in_a  in  LANES*WIDTH  minuend pixels; lane i occupies [i*WIDTH +: WIDTH].
- in_b  in  LANES*WIDTH  subtrahend pixels, same packing as in_a.
- thr  in  WIDTH  edge threshold; sampled together with the input beat.
- out_valid  out  1  output beat valid.
- out_ready  in  1  downstream accepts the output beat.
- out_abs  out  LANES*WIDTH  per-lane |a-b|.
- out_sign  out  LANES  per-lane 1 when a < b.
- out_flag  out  LANES  per-lane 1 when |a-b| > thr (strict).
- out_sad  out  SAD_W  sum of all lanes' out_abs.

Behaviour:
- Reset (async assert, released synchronously to clk):
  - s1_valid, s2_valid, out_valid clear to 0.
  - out_abs, out_sign, out_flag, out_sad clear to 0.
  - in_ready = 1 one cycle after reset release, and also combinationally while the pipe is empty.
- Two-stage pipeline, latency 2 cycles from accepted input to out_valid when not stalled; throughput 1 beat/cycle.
- Stage 1, on accept:
  - Per lane, compute d = {1'b0,a} - {1'b0,b} in WIDTH+1 bits (two's complement).
  - Register d, the lane borrow (d[WIDTH]), thr and s1_valid.
- Stage 2:
  - abs = borrow ? (~d[WIDTH-1:0] + 1) : d[WIDTH-1:0]; the result always fits WIDTH bits (max 2^WIDTH - 1, no saturation needed).
  - sign = borrow; flag = (abs > thr).
  - sad = zero-extended sum of all abs.
  - Register these outputs and out_valid.
- Flow control, global stall:
  - adv = !out_valid || out_ready.
  - in_ready = adv.
  - Accept occurs when in_valid && in_ready.
  - When adv = 1, both stages shift; a bubble (s1_valid = 0) propagates as out_valid = 0.
  - When adv = 0, all stage registers, including thr and outputs, hold unchanged.
- out_* are stable while out_valid && !out_ready (AXI-stream style). in_valid may drop without acceptance; no combinational path from in_valid to in_ready.
- Boundary cases:
  - a == b: abs = 0, sign = 0, flag = 0.
  - a = 0, b = 2^WIDTH - 1: abs = 2^WIDTH - 1, sign = 1.
  - thr = 2^WIDTH - 1: flag is never set.
  - thr = 0: flag = (abs != 0).
  - Simultaneous output drain and input accept in the same cycle is required (no bubble).
  - Reset mid-stream discards all in-flight beats; no partial beat is emitted after reset.
- out_sad for LANES = 1 equals out_abs.
- No state machine beyond the valid pipeline. The valid bits form the only control state: EMPTY, S1 only, S2 only, FULL.

Decomposition:
- Package abs_diff_pkg holds:
  - the clog2 function;
  - the SAD width rule;
  - the lane-slice helper macro/function.
- Sub-module abs_diff_lane (combinational, WIDTH param):
  - inputs: d (WIDTH+1) and thr;
  - outputs: abs, sign, flag;
  - instantiated LANES times in stage 2 via generate.
- SAD adder stays in the top level as a linear or tree sum over LANES.

Test Plan (WIDTH=8, LANES=4 unless noted):
- Lanes a = {200, 50, 0, 77}, b = {50, 200, 255, 77}, thr = 100 -> 2 cycles later abs = {150, 150, 255, 0}, sign = {0, 1, 1, 0}, flag = {1, 1, 1, 0}, sad = 555.
- Threshold edge: diff 20 with thr = 20 -> flag 0; diff 21 -> flag 1; thr = 0 with diff 0 -> flag 0; thr = 255 with diff 255 -> flag 0.
- Streaming: 16 back-to-back beats with out_ready = 1 -> in_ready stays 1, 16 outputs on consecutive cycles in order; first output arrives 2 cycles after the first accept.
- Backpressure: out_ready = 0 for 3 cycles while out_valid = 1 -> in_ready = 0 and out_* bit-stable. On out_ready = 1, the stalled beat drains and the next beat follows the next cycle, with no loss or duplication. Verify with a scoreboard against a reference model.
- Reset mid-stream: assert rst with both stages full -> out_valid = 0 and outputs = 0 immediately (async). After release, only beats accepted post-reset appear.
- Parameter sweep: WIDTH = 10, LANES = 1 -> a = 0, b = 1023 gives abs = 1023, sign = 1, and sad == abs. Random 10k beats match the reference model.

Source files
------------

// File: rtl/abs_diff_pkg.sv
// Shared helpers for the absolute-difference pipeline: width rules and lane slicing.
package abs_diff_pkg;

  function automatic int unsigned clog2(input int unsigned value);
    int unsigned result;
    result = 0;
    for (int i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(value)) begin
        result = i + 1;
      end
    end
    return result;
  endfunction

  // A single lane needs no carry headroom, so the SAD collapses to the lane width.
  function automatic int unsigned sad_width(input int unsigned width, input int unsigned lanes);
    return (lanes == 1) ? width : width + clog2(lanes);
  endfunction

  function automatic int unsigned lane_lo(input int unsigned lane, input int unsigned width);
    return lane * width;
  endfunction

endpackage

// File: rtl/abs_diff_lane.sv
// Combinational per-lane magnitude, sign and threshold flag from a registered difference.
module abs_diff_lane
  import abs_diff_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic [WIDTH:0]   i_d,
  input  logic [WIDTH-1:0] i_thr,
  output logic [WIDTH-1:0] o_abs,
  output logic             o_sign,
  output logic             o_flag
);

  logic [WIDTH-1:0] w_mag;

  // Negating the low bits of a borrowed difference always fits WIDTH bits.
  assign w_mag  = i_d[WIDTH] ? (~i_d[WIDTH-1:0] + WIDTH'(1)) : i_d[WIDTH-1:0];
  assign o_abs  = w_mag;
  assign o_sign = i_d[WIDTH];
  assign o_flag = (w_mag > i_thr);

endmodule

// File: rtl/abs_diff_pipe.sv
// Two-stage valid/ready absolute-difference engine: per-lane |a-b|, sign, edge flag and SAD.
module abs_diff_pipe
  import abs_diff_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned LANES = 4,
  localparam int unsigned SAD_W = sad_width(WIDTH, LANES)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [LANES*WIDTH-1:0] in_a,
  input  logic [LANES*WIDTH-1:0] in_b,
  input  logic [WIDTH-1:0]       thr,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [LANES*WIDTH-1:0] out_abs,
  output logic [LANES-1:0]       out_sign,
  output logic [LANES-1:0]       out_flag,
  output logic [SAD_W-1:0]       out_sad
);

  logic                   w_adv;
  logic                   r_s1_valid;
  logic [WIDTH:0]         r_d [LANES];
  logic [WIDTH-1:0]       r_thr;

  logic [WIDTH-1:0]       w_abs [LANES];
  logic [LANES*WIDTH-1:0] w_abs_flat;
  logic [LANES-1:0]       w_sign;
  logic [LANES-1:0]       w_flag;
  logic [SAD_W-1:0]       w_sad;

  logic                   r_out_valid;
  logic [LANES*WIDTH-1:0] r_abs;
  logic [LANES-1:0]       r_sign;
  logic [LANES-1:0]       r_flag;
  logic [SAD_W-1:0]       r_sad;

  // Global stall: the whole pipe moves only when the output slot is free or draining.
  assign w_adv    = !r_out_valid || out_ready;
  assign in_ready = w_adv;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s1_valid <= 1'b0;
      r_thr      <= '0;
      for (int i = 0; i < int'(LANES); i++) begin
        r_d[i] <= '0;
      end
    end else if (w_adv) begin
      r_s1_valid <= in_valid;
      if (in_valid) begin
        r_thr <= thr;
        for (int i = 0; i < int'(LANES); i++) begin
          r_d[i] <= {1'b0, in_a[lane_lo(i, WIDTH) +: WIDTH]}
                  - {1'b0, in_b[lane_lo(i, WIDTH) +: WIDTH]};
        end
      end
    end
  end

  for (genvar g = 0; g < int'(LANES); g++) begin : g_lane
    abs_diff_lane #(
      .WIDTH(WIDTH)
    ) u_lane (
      .i_d   (r_d[g]),
      .i_thr (r_thr),
      .o_abs (w_abs[g]),
      .o_sign(w_sign[g]),
      .o_flag(w_flag[g])
    );
  end

  always_comb begin
    w_abs_flat = '0;
    w_sad      = '0;
    for (int i = 0; i < int'(LANES); i++) begin
      w_abs_flat[lane_lo(i, WIDTH) +: WIDTH] = w_abs[i];
      w_sad = w_sad + SAD_W'(w_abs[i]);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_out_valid <= 1'b0;
      r_abs       <= '0;
      r_sign      <= '0;
      r_flag      <= '0;
      r_sad       <= '0;
    end else if (w_adv) begin
      r_out_valid <= r_s1_valid;
      if (r_s1_valid) begin
        r_abs  <= w_abs_flat;
        r_sign <= w_sign;
        r_flag <= w_flag;
        r_sad  <= w_sad;
      end
    end
  end

  assign out_valid = r_out_valid;
  assign out_abs   = r_abs;
  assign out_sign  = r_sign;
  assign out_flag  = r_flag;
  assign out_sad   = r_sad;

endmodule

// File: tb/tb_abs_diff_pipe.sv
// Self-checking bench: directed vectors, flow-control sequences and random scoreboarding.
module tb_abs_diff_pipe;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // 8-bit x 4-lane instance
  logic        in_valid0, in_ready0, out_valid0, out_ready0;
  logic [31:0] in_a0, in_b0, out_abs0;
  logic [7:0]  thr0;
  logic [3:0]  out_sign0, out_flag0;
  logic [9:0]  out_sad0;

  // 10-bit x 1-lane instance
  logic        in_valid1, in_ready1, out_valid1, out_ready1;
  logic [9:0]  in_a1, in_b1, thr1, out_abs1, out_sad1;
  logic [0:0]  out_sign1, out_flag1;

  abs_diff_pipe #(.WIDTH(8), .LANES(4)) dut0 (
    .clk(clk), .rst(rst), .in_valid(in_valid0), .in_ready(in_ready0),
    .in_a(in_a0), .in_b(in_b0), .thr(thr0), .out_valid(out_valid0), .out_ready(out_ready0),
    .out_abs(out_abs0), .out_sign(out_sign0), .out_flag(out_flag0), .out_sad(out_sad0)
  );

  abs_diff_pipe #(.WIDTH(10), .LANES(1)) dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid1), .in_ready(in_ready1),
    .in_a(in_a1), .in_b(in_b1), .thr(thr1), .out_valid(out_valid1), .out_ready(out_ready1),
    .out_abs(out_abs1), .out_sign(out_sign1), .out_flag(out_flag1), .out_sad(out_sad1)
  );

  typedef struct {
    logic [31:0] a, b;
    logic [7:0]  thr;
    logic [31:0] abs;
    logic [3:0]  sign, flag;
    logic [9:0]  sad;
  } vec_t;

  typedef struct {
    logic [31:0] abs;
    logic [3:0]  sign, flag;
    logic [9:0]  sad;
  } exp0_t;

  typedef struct {
    logic [9:0] abs;
    logic       sign, flag;
    logic [9:0] sad;
  } exp1_t;

  int    n_checks = 0;
  int    n_err    = 0;
  int    pops0    = 0;
  int    pops1    = 0;
  exp0_t q0[$];
  exp1_t q1[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] pack4(input int l0, input int l1, input int l2, input int l3);
    return {l3[7:0], l2[7:0], l1[7:0], l0[7:0]};
  endfunction

  // Reference: plain integer arithmetic per lane.
  function automatic exp0_t model0(input logic [31:0] a, input logic [31:0] b,
                                   input logic [7:0] t);
    exp0_t e;
    int    x, y, d, s;
    s = 0;
    e.abs = '0; e.sign = '0; e.flag = '0;
    for (int i = 0; i < 4; i++) begin
      x = int'(a[i*8 +: 8]);
      y = int'(b[i*8 +: 8]);
      d = (x >= y) ? x - y : y - x;
      e.abs[i*8 +: 8] = 8'(d);
      e.sign[i] = (x < y);
      e.flag[i] = (d > int'(t));
      s += d;
    end
    e.sad = 10'(s);
    return e;
  endfunction

  function automatic exp1_t model1(input logic [9:0] a, input logic [9:0] b, input logic [9:0] t);
    exp1_t e;
    int    x, y, d;
    x = int'(a);
    y = int'(b);
    d = (x >= y) ? x - y : y - x;
    e.abs  = 10'(d);
    e.sign = (x < y);
    e.flag = (d > int'(t));
    e.sad  = 10'(d);
    return e;
  endfunction

  always @(negedge clk) begin
    if (rst === 1'b0) begin
      check("in_ready0_rule", 64'(in_ready0), 64'(!(out_valid0 && !out_ready0)));
      if (out_valid0) begin
        if (q0.size() == 0) begin
          n_checks++; n_err++;
          $display("FAIL sb0_extra: got out_valid0=1 with abs 0x%0h, expected no beat", out_abs0);
        end else begin
          check("sb0_abs", 64'(out_abs0), 64'(q0[0].abs));
          check("sb0_sign", 64'(out_sign0), 64'(q0[0].sign));
          check("sb0_flag", 64'(out_flag0), 64'(q0[0].flag));
          check("sb0_sad", 64'(out_sad0), 64'(q0[0].sad));
          if (out_ready0) begin
            void'(q0.pop_front());
            pops0++;
          end
        end
      end
      if (in_valid0 && in_ready0) q0.push_back(model0(in_a0, in_b0, thr0));
    end
  end

  always @(negedge clk) begin
    if (rst === 1'b0) begin
      check("in_ready1_rule", 64'(in_ready1), 64'(!(out_valid1 && !out_ready1)));
      if (out_valid1) begin
        if (q1.size() == 0) begin
          n_checks++; n_err++;
          $display("FAIL sb1_extra: got out_valid1=1 with abs 0x%0h, expected no beat", out_abs1);
        end else begin
          check("sb1_abs", 64'(out_abs1), 64'(q1[0].abs));
          check("sb1_sign", 64'(out_sign1), 64'(q1[0].sign));
          check("sb1_flag", 64'(out_flag1), 64'(q1[0].flag));
          check("sb1_sad", 64'(out_sad1), 64'(q1[0].sad));
          if (out_ready1) begin
            void'(q1.pop_front());
            pops1++;
          end
        end
      end
      if (in_valid1 && in_ready1) q1.push_back(model1(in_a1, in_b1, thr1));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rand_beat0();
    in_a0 = $urandom();
    in_b0 = $urandom();
    if ($urandom_range(0, 7) == 0) in_b0 = in_a0;
    thr0 = 8'($urandom());
  endtask

  vec_t tbl[5];
  int   p;
  int   acc;
  int   cyc;

  initial begin
    rst = 1'b0;
    in_valid0 = 1'b0; in_a0 = '0; in_b0 = '0; thr0 = '0; out_ready0 = 1'b1;
    in_valid1 = 1'b0; in_a1 = '0; in_b1 = '0; thr1 = '0; out_ready1 = 1'b1;
    #1 rst = 1'b1;
    #2;
    check("rst_out_valid0", 64'(out_valid0), 64'd0);
    check("rst_out_abs0", 64'(out_abs0), 64'd0);
    check("rst_out_sign0", 64'(out_sign0), 64'd0);
    check("rst_out_flag0", 64'(out_flag0), 64'd0);
    check("rst_out_sad0", 64'(out_sad0), 64'd0);
    check("rst_in_ready0", 64'(in_ready0), 64'd1);
    check("rst_out_valid1", 64'(out_valid1), 64'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("post_rst_in_ready0", 64'(in_ready0), 64'd1);

    tbl[0] = '{pack4(200, 50, 0, 77), pack4(50, 200, 255, 77), 8'd100,
               pack4(150, 150, 255, 0), 4'b0110, 4'b0111, 10'd555};
    tbl[1] = '{pack4(20, 21, 0, 255), pack4(0, 0, 0, 0), 8'd20,
               pack4(20, 21, 0, 255), 4'b0000, 4'b1010, 10'd296};
    tbl[2] = '{pack4(5, 9, 9, 0), pack4(5, 10, 0, 255), 8'd0,
               pack4(0, 1, 9, 255), 4'b1010, 4'b1110, 10'd265};
    tbl[3] = '{pack4(255, 0, 100, 3), pack4(0, 255, 100, 200), 8'd255,
               pack4(255, 255, 0, 197), 4'b1010, 4'b0000, 10'd707};
    tbl[4] = '{pack4(0, 10, 30, 128), pack4(20, 31, 10, 127), 8'd20,
               pack4(20, 21, 20, 1), 4'b0011, 4'b0010, 10'd62};

    // Directed vectors, one beat at a time: result visible two edges after accept.
    for (int i = 0; i < 5; i++) begin
      in_a0 = tbl[i].a; in_b0 = tbl[i].b; thr0 = tbl[i].thr; in_valid0 = 1'b1;
      tick();
      in_valid0 = 1'b0;
      tick();
      @(negedge clk);
      check($sformatf("tbl%0d_valid", i), 64'(out_valid0), 64'd1);
      check($sformatf("tbl%0d_abs", i), 64'(out_abs0), 64'(tbl[i].abs));
      check($sformatf("tbl%0d_sign", i), 64'(out_sign0), 64'(tbl[i].sign));
      check($sformatf("tbl%0d_flag", i), 64'(out_flag0), 64'(tbl[i].flag));
      check($sformatf("tbl%0d_sad", i), 64'(out_sad0), 64'(tbl[i].sad));
    end
    tick();

    // Streaming: 16 back-to-back beats, outputs on consecutive cycles after 2-cycle latency.
    p = pops0;
    for (int c = 0; c < 18; c++) begin
      in_valid0 = (c < 16);
      rand_beat0();
      @(negedge clk);
      if (c < 16) check("stream_in_ready", 64'(in_ready0), 64'd1);
      check($sformatf("stream_out_valid_c%0d", c), 64'(out_valid0), 64'(c >= 2 && c <= 17));
      @(posedge clk);
      #1;
    end
    in_valid0 = 1'b0;
    tick();
    check("stream_pop_count", 64'(pops0 - p), 64'd16);

    // Backpressure: stall three cycles mid-stream.
    for (int c = 0; c < 12; c++) begin
      in_valid0  = 1'b1;
      out_ready0 = !(c >= 4 && c <= 6);
      rand_beat0();
      @(negedge clk);
      if (c >= 4 && c <= 6) begin
        check("bp_in_ready", 64'(in_ready0), 64'd0);
        check("bp_out_valid", 64'(out_valid0), 64'd1);
      end
      @(posedge clk);
      #1;
    end
    in_valid0 = 1'b0; out_ready0 = 1'b1;
    repeat (4) tick();
    check("bp_drained", 64'(q0.size()), 64'd0);

    // Reset mid-stream with both stages full.
    out_ready0 = 1'b0;
    for (int c = 0; c < 3; c++) begin
      in_valid0 = 1'b1;
      in_a0 = pack4(255, 200, 100, 50); in_b0 = pack4(0, 1, 2, 3); thr0 = 8'd10;
      tick();
    end
    rst = 1'b1;
    in_valid0 = 1'b0;
    q0.delete();
    #1;
    check("mid_rst_out_valid", 64'(out_valid0), 64'd0);
    check("mid_rst_out_abs", 64'(out_abs0), 64'd0);
    check("mid_rst_out_sad", 64'(out_sad0), 64'd0);
    check("mid_rst_out_flag", 64'(out_flag0), 64'd0);
    check("mid_rst_out_sign", 64'(out_sign0), 64'd0);
    tick();
    rst = 1'b0;
    out_ready0 = 1'b1;
    @(negedge clk);
    check("post_mid_rst_valid", 64'(out_valid0), 64'd0);
    @(posedge clk);
    #1;
    p = pops0;
    for (int c = 0; c < 2; c++) begin
      in_valid0 = 1'b1;
      rand_beat0();
      tick();
    end
    in_valid0 = 1'b0;
    repeat (4) tick();
    check("post_rst_beats", 64'(pops0 - p), 64'd2);

    // Random traffic on the 4-lane instance.
    for (int c = 0; c < 2000; c++) begin
      in_valid0  = ($urandom_range(0, 3) != 0);
      out_ready0 = ($urandom_range(0, 3) != 0);
      rand_beat0();
      if ($urandom_range(0, 15) == 0) thr0 = 8'd0;
      if ($urandom_range(0, 15) == 0) thr0 = 8'd255;
      tick();
    end
    in_valid0 = 1'b0; out_ready0 = 1'b1;
    repeat (4) tick();
    check("rand0_drained", 64'(q0.size()), 64'd0);

    // Single-lane 10-bit instance: extreme boundary, then random beats.
    in_a1 = 10'd0; in_b1 = 10'd1023; thr1 = 10'd1022; in_valid1 = 1'b1;
    tick();
    in_valid1 = 1'b0;
    tick();
    @(negedge clk);
    check("w10_valid", 64'(out_valid1), 64'd1);
    check("w10_abs", 64'(out_abs1), 64'd1023);
    check("w10_sign", 64'(out_sign1), 64'd1);
    check("w10_flag", 64'(out_flag1), 64'd1);
    check("w10_sad", 64'(out_sad1), 64'd1023);
    @(posedge clk);
    #1;

    acc = 0;
    cyc = 0;
    while (acc < 10000 && cyc < 40000) begin
      in_valid1  = ($urandom_range(0, 3) != 0);
      out_ready1 = ($urandom_range(0, 3) != 0);
      in_a1 = 10'($urandom());
      in_b1 = 10'($urandom());
      if ($urandom_range(0, 7) == 0) in_b1 = in_a1;
      thr1 = 10'($urandom());
      @(negedge clk);
      if (in_valid1 && in_ready1) acc++;
      @(posedge clk);
      #1;
      cyc++;
    end
    check("rand1_accepts", 64'(acc), 64'd10000);
    in_valid1 = 1'b0; out_ready1 = 1'b1;
    repeat (4) tick();
    check("rand1_drained", 64'(q1.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
